// File: rtl/minterm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : minterm_pkg
//  Description : Shared widths and FSM state encoding for the minterm scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package minterm_pkg;

    localparam int c_VEC_W   = 4;             // width of the test vector {x,y,w,z}
    localparam int c_TBL_W   = 16;            // one truth-table bit per vector value
    localparam int c_CNT_W   = 5;             // holds 0..16 set bits
    localparam int c_START_W = c_VEC_W + 1;   // search start may point one past the top

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/minterm_find_next.sv
`default_nettype none
// ============================================================================
//  Module      : minterm_find_next
//  Description : Combinational search for the lowest set table bit at or
//                above a start index. A start index of 16 finds nothing.
//  Revision    : 1.0 - initial release
// ============================================================================
module minterm_find_next
    import minterm_pkg::*;
(
    input  logic [c_TBL_W-1:0]   i_table,
    input  logic [c_START_W-1:0] i_start,
    output logic                 o_found,
    output logic [c_VEC_W-1:0]   o_index
);

    // Walk from the top down so the lowest qualifying index is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int i = c_TBL_W - 1; i >= 0; i--) begin
            if (i_table[i] && (c_START_W'(i) >= i_start)) begin
                o_found = 1'b1;
                o_index = c_VEC_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/minterm_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : minterm_scanner
//  Description : Sweeps all 16 input vectors of an external 4-input function,
//                captures its truth table and set-bit count, then streams the
//                set minterm indices out over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module minterm_scanner
    import minterm_pkg::*;
#(
    parameter int SETTLE = 1
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [c_VEC_W-1:0] vec,
    input  logic               f_in,
    output logic               busy,
    output logic               done,
    output logic [c_TBL_W-1:0] truth_table,
    output logic [c_CNT_W-1:0] count,
    output logic               m_valid,
    output logic [c_VEC_W-1:0] m_index,
    input  logic               m_ready
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_VEC_W-1:0]   r_vec;
    logic [3:0]           r_settle;
    logic [c_TBL_W-1:0]   r_table;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_m_valid;
    logic [c_VEC_W-1:0]   r_m_index;

    logic                 w_hold_end;
    logic                 w_last_vec;
    logic                 w_transfer;
    logic [c_TBL_W-1:0]   w_table_cap;
    logic [c_TBL_W-1:0]   w_fn_table;
    logic [c_START_W-1:0] w_fn_start;
    logic                 w_fn_found;
    logic [c_VEC_W-1:0]   w_fn_index;

    assign w_hold_end  = (r_settle == 4'(SETTLE));
    assign w_last_vec  = (r_vec == {c_VEC_W{1'b1}});
    assign w_transfer  = r_m_valid & m_ready;
    // Table as it will look once the current vector's response is captured.
    assign w_table_cap = r_table | (c_TBL_W'(f_in) << r_vec);

    // At the end of the scan the search runs on the freshly completed table from
    // index 0, so the first minterm is already offered on the first EMIT cycle.
    assign w_fn_table = (r_state == ST_EMIT) ? r_table : w_table_cap;
    assign w_fn_start = (r_state == ST_EMIT) ? ({1'b0, r_m_index} + c_START_W'(1)) : '0;

    minterm_find_next u_find_next (
        .i_table (w_fn_table),
        .i_start (w_fn_start),
        .o_found (w_fn_found),
        .o_index (w_fn_index)
    );

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_SCAN;
            ST_SCAN: if (w_hold_end && w_last_vec) w_state_nxt = w_fn_found ? ST_EMIT : ST_FIN;
            ST_EMIT: if (w_transfer && !w_fn_found) w_state_nxt = ST_FIN;
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Scan datapath and minterm output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vec     <= '0;
            r_settle  <= '0;
            r_table   <= '0;
            r_count   <= '0;
            r_m_valid <= 1'b0;
            r_m_index <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_vec    <= '0;
                        r_settle <= '0;
                        r_table  <= '0;
                        r_count  <= '0;
                    end
                end
                ST_SCAN: begin
                    if (w_hold_end) begin
                        r_settle <= '0;
                        r_table  <= w_table_cap;
                        r_count  <= r_count + c_CNT_W'(f_in);
                        r_vec    <= r_vec + c_VEC_W'(1);   // wraps back to 0 after 15
                        if (w_last_vec) begin
                            r_m_valid <= w_fn_found;
                            r_m_index <= w_fn_index;
                        end
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                ST_EMIT: begin
                    if (w_transfer) begin
                        r_m_valid <= w_fn_found;
                        if (w_fn_found) r_m_index <= w_fn_index;
                    end
                end
                default: ;
            endcase
        end
    end

    assign vec         = r_vec;
    assign truth_table = r_table;
    assign count       = r_count;
    assign m_valid     = r_m_valid;
    assign m_index     = r_m_index;
    assign busy        = (r_state == ST_SCAN) || (r_state == ST_EMIT);
    assign done        = (r_state == ST_FIN);

endmodule
`default_nettype wire

// File: tb/tb_minterm_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_minterm_scanner
//  Description : Self-checking bench for minterm_scanner (SETTLE=1 main
//                instance, SETTLE=0 secondary instance for the all-ones case).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_minterm_scanner;

    localparam int SETTLE   = 1;
    localparam int SCAN_CYC = 16 * (SETTLE + 1);

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        m_ready;
    logic [15:0] func;
    logic        f_in;
    logic [3:0]  vec;
    logic        busy, done, m_valid;
    logic [15:0] tbl;
    logic [4:0]  count;
    logic [3:0]  m_index;

    // Second instance, SETTLE=0, driven by an all-ones function.
    logic        start0;
    logic [15:0] func0 = 16'hFFFF;
    logic        f_in0;
    logic [3:0]  vec0;
    logic        busy0, done0, m_valid0;
    logic [15:0] tbl0;
    logic [4:0]  count0;
    logic [3:0]  m_index0;

    always #5 clk = ~clk;

    assign f_in  = func[vec];
    assign f_in0 = func0[vec0];

    minterm_scanner #(.SETTLE(SETTLE)) u_dut (
        .clk(clk), .reset(reset), .start(start), .vec(vec), .f_in(f_in),
        .busy(busy), .done(done), .truth_table(tbl), .count(count),
        .m_valid(m_valid), .m_index(m_index), .m_ready(m_ready)
    );

    minterm_scanner #(.SETTLE(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .vec(vec0), .f_in(f_in0),
        .busy(busy0), .done(done0), .truth_table(tbl0), .count(count0),
        .m_valid(m_valid0), .m_index(m_index0), .m_ready(1'b1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model state ----------------
    bit          m_active = 1'b0;
    int          k;
    int          exp_q[$];
    int          seen_q[$];
    int          exp_done_k;
    logic [15:0] exp_tbl, hold_tbl = '0;
    int          exp_cnt, hold_cnt = 0;
    int          done_cnt = 0, accept_cnt = 0;
    int          first_valid_k, done_k, idx8_cycles;

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            exp_q.delete();
            hold_tbl = '0;
            hold_cnt = 0;
        end else if (!m_active) begin
            check("idle_busy",  busy,    0);
            check("idle_done",  done,    0);
            check("idle_valid", m_valid, 0);
            check("idle_vec",   vec,     0);
            check("hold_table", tbl,     hold_tbl);
            check("hold_count", count,   hold_cnt);
            if (start) begin
                m_active = 1'b1;
                k        = -1;
                accept_cnt++;
                exp_tbl  = func;
                exp_cnt  = $countones(func);
                exp_q.delete();
                seen_q.delete();
                for (int i = 0; i < 16; i++) if (func[i]) exp_q.push_back(i);
                exp_done_k    = (exp_q.size() == 0) ? SCAN_CYC : 32'h3FFF_FFFF;
                first_valid_k = -1;
            end
        end else begin
            k++;
            check("vec",     vec,     (k < SCAN_CYC) ? k / (SETTLE + 1) : 0);
            check("busy",    busy,    (k < exp_done_k) ? 1 : 0);
            check("done",    done,    (k == exp_done_k) ? 1 : 0);
            check("m_valid", m_valid, (k >= SCAN_CYC && exp_q.size() > 0) ? 1 : 0);
            if (m_valid && first_valid_k < 0) first_valid_k = k;
            if (m_valid && m_index == 4'd8) idx8_cycles++;
            if (m_valid && exp_q.size() > 0) check("m_index", m_index, exp_q[0]);
            if (k == exp_done_k) begin
                check("end_table", tbl,   exp_tbl);
                check("end_count", count, exp_cnt);
                hold_tbl = exp_tbl;
                hold_cnt = exp_cnt;
                done_k   = k;
                done_cnt++;
                m_active = 1'b0;
            end else if (m_valid && m_ready && exp_q.size() > 0) begin
                seen_q.push_back(int'(m_index));
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_done_k = k + 1;
            end
        end
    end

    // Start one operation and run it to completion. Optional ready stall on
    // index 8 and stray start pulses during SCAN and EMIT.
    task automatic run_case(input logic [15:0] f, input bit stall, input bit inject);
        int n = 0;
        int stall_left = 5;
        bit emit_inj = 1'b0;
        func = f;
        idx8_cycles = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (!m_active) break;
            if (stall && m_valid && m_index == 4'd8 && stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else begin
                m_ready = 1'b1;
            end
            if (inject && n == 5) start = 1'b1;
            if (inject && m_valid && !emit_inj) begin
                start    = 1'b1;
                emit_inj = 1'b1;
            end
        end
        check("run_timeout", (n >= 400) ? 1 : 0, 0);
        m_ready = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec"},   vec,     0);
        check({tag, "_busy"},  busy,    0);
        check({tag, "_done"},  done,    0);
        check({tag, "_table"}, tbl,     0);
        check({tag, "_count"}, count,   0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_index"}, m_index, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; start0 = 1'b0; m_ready = 1'b1; func = '0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("rst");
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // SoP(2,8,13,14)
        run_case(16'h6104, 1'b0, 1'b0);
        check("sop_table", tbl, 16'h6104);
        check("sop_count", count, 4);
        check("sop_nseen", seen_q.size(), 4);
        if (seen_q.size() == 4) begin
            check("sop_seq0", seen_q[0], 2);
            check("sop_seq1", seen_q[1], 8);
            check("sop_seq2", seen_q[2], 13);
            check("sop_seq3", seen_q[3], 14);
        end
        check("sop_scan_cycles", first_valid_k, 32);
        check("sop_done_k", done_k, 36);

        // f = 0
        run_case(16'h0000, 1'b0, 1'b0);
        check("zero_table", tbl, 0);
        check("zero_count", count, 0);
        check("zero_nseen", seen_q.size(), 0);
        check("zero_done_k", done_k, 32);

        // boundary indices 0 and 15
        run_case(16'h8001, 1'b0, 1'b0);
        check("edge_nseen", seen_q.size(), 2);
        if (seen_q.size() == 2) begin
            check("edge_seq0", seen_q[0], 0);
            check("edge_seq1", seen_q[1], 15);
        end

        // ready stall while index 8 is offered
        run_case(16'h6104, 1'b1, 1'b0);
        check("stall_idx8_cycles", idx8_cycles, 6);
        check("stall_nseen", seen_q.size(), 4);

        // stray starts during SCAN and EMIT
        n = done_cnt;
        run_case(16'h6104, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1 check("inject_one_done", done_cnt - n, 1);

        // reset in the middle of the scan at vec=7
        func = 16'h6104;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (vec != 4'd7 && n < 100) begin @(posedge clk); #1; n++; end
        check("reach_vec7", (n < 100) ? 1 : 0, 1);
        #1 reset = 1'b1;
        #1 check_all_zero("midrst");
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        run_case(16'h6104, 1'b0, 1'b0);
        check("post_rst_table", tbl, 16'h6104);
        check("post_rst_count", count, 4);

        check("total_dones", done_cnt, 6);
        check("total_accepts", accept_cnt, 7);

        // SETTLE=0, f = 1 on the second instance
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        n = 0;
        while (!m_valid0 && n < 100) begin @(posedge clk); #1; n++; end
        check("s0_scan_cycles", n, 16);
        for (int i = 0; i < 16; i++) begin
            check("s0_valid", m_valid0, 1);
            check("s0_index", m_index0, i);
            @(posedge clk); #1;
        end
        check("s0_done",  done0,  1);
        check("s0_busy",  busy0,  0);
        check("s0_valid_end", m_valid0, 0);
        check("s0_table", tbl0,   16'hFFFF);
        check("s0_count", count0, 16);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
